// File: rtl/gates_pkg.sv
// +----------------------------------------------------------------------+
// | gates_pkg: shared constants and types for reg_gates / gates_core.    |
// | Optional macro: GATES_EXT_EN (adds XOR/NAND/NOR/XNOR result fields). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package gates_pkg;

  localparam int GATES_DEFAULT_WIDTH = 1;
  localparam int GATES_MAX_WIDTH     = 64;

  // Results clear to zero; outputNot included, so it does not reset to ~0.
  localparam logic [GATES_MAX_WIDTH-1:0] GATES_RESULT_RST = '0;

`ifdef GATES_EXT_EN
  typedef struct packed {
    logic [GATES_MAX_WIDTH-1:0] res_or;
    logic [GATES_MAX_WIDTH-1:0] res_and;
    logic [GATES_MAX_WIDTH-1:0] res_not;
    logic [GATES_MAX_WIDTH-1:0] res_xor;
    logic [GATES_MAX_WIDTH-1:0] res_nand;
    logic [GATES_MAX_WIDTH-1:0] res_nor;
    logic [GATES_MAX_WIDTH-1:0] res_xnor;
  } gates_result_t;
`endif

endpackage

`default_nettype wire

// File: rtl/gates_core.sv
// +----------------------------------------------------------------------+
// | gates_core: combinational bit-wise gate functions of two operands.   |
// | Optional macro: GATES_EXT_EN (XOR/NAND/NOR/XNOR outputs).            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module gates_core
  import gates_pkg::*;
#(
  parameter int WIDTH = GATES_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef GATES_EXT_EN
  output logic [WIDTH-1:0] xor_o,
  output logic [WIDTH-1:0] nand_o,
  output logic [WIDTH-1:0] nor_o,
  output logic [WIDTH-1:0] xnor_o,
`endif
  output logic [WIDTH-1:0] or_o,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] not_o
);

  assign or_o  = a_i | b_i;
  assign and_o = a_i & b_i;
  assign not_o = ~a_i;

`ifdef GATES_EXT_EN
  assign xor_o  = a_i ^ b_i;
  assign nand_o = ~(a_i & b_i);
  assign nor_o  = ~(a_i | b_i);
  assign xnor_o = ~(a_i ^ b_i);
`endif

endmodule

`default_nettype wire

// File: rtl/reg_gates.sv
// +----------------------------------------------------------------------+
// | reg_gates: registered (or bypassed) bit-wise OR/AND/NOT gate block.  |
// | Optional macro: GATES_EXT_EN (adds XOR/NAND/NOR/XNOR outputs).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_gates
  import gates_pkg::*;
#(
  parameter int WIDTH      = GATES_DEFAULT_WIDTH,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inValid,
  output logic [WIDTH-1:0] outputOr,
  output logic [WIDTH-1:0] outputAnd,
  output logic [WIDTH-1:0] outputNot,
`ifdef GATES_EXT_EN
  output logic [WIDTH-1:0] outputXor,
  output logic [WIDTH-1:0] outputNand,
  output logic [WIDTH-1:0] outputNor,
  output logic [WIDTH-1:0] outputXnor,
`endif
  output logic             outValid
);

  localparam logic [WIDTH-1:0] RST_VAL = GATES_RESULT_RST[WIDTH-1:0];

  logic [WIDTH-1:0] or_w, and_w, not_w;
`ifdef GATES_EXT_EN
  logic [WIDTH-1:0] xor_w, nand_w, nor_w, xnor_w;
`endif

  gates_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (inA),
    .b_i   (inB),
`ifdef GATES_EXT_EN
    .xor_o (xor_w),
    .nand_o(nand_w),
    .nor_o (nor_w),
    .xnor_o(xnor_w),
`endif
    .or_o  (or_w),
    .and_o (and_w),
    .not_o (not_w)
  );

  generate
    if (REGISTERED) begin : g_registered
      logic [WIDTH-1:0] or_d, and_d, not_d;
      logic [WIDTH-1:0] or_q, and_q, not_q;
      logic             valid_q;
`ifdef GATES_EXT_EN
      logic [WIDTH-1:0] xor_d, nand_d, nor_d, xnor_d;
      logic [WIDTH-1:0] xor_q, nand_q, nor_q, xnor_q;
`endif

      // Result registers only load on a valid cycle; otherwise they hold.
      always_comb begin
        or_d  = inValid ? or_w  : or_q;
        and_d = inValid ? and_w : and_q;
        not_d = inValid ? not_w : not_q;
`ifdef GATES_EXT_EN
        xor_d  = inValid ? xor_w  : xor_q;
        nand_d = inValid ? nand_w : nand_q;
        nor_d  = inValid ? nor_w  : nor_q;
        xnor_d = inValid ? xnor_w : xnor_q;
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          or_q    <= RST_VAL;
          and_q   <= RST_VAL;
          not_q   <= RST_VAL;
          valid_q <= 1'b0;
`ifdef GATES_EXT_EN
          xor_q   <= RST_VAL;
          nand_q  <= RST_VAL;
          nor_q   <= RST_VAL;
          xnor_q  <= RST_VAL;
`endif
        end else begin
          or_q    <= or_d;
          and_q   <= and_d;
          not_q   <= not_d;
          valid_q <= inValid;
`ifdef GATES_EXT_EN
          xor_q   <= xor_d;
          nand_q  <= nand_d;
          nor_q   <= nor_d;
          xnor_q  <= xnor_d;
`endif
        end
      end

      assign outputOr  = or_q;
      assign outputAnd = and_q;
      assign outputNot = not_q;
      assign outValid  = valid_q;
`ifdef GATES_EXT_EN
      assign outputXor  = xor_q;
      assign outputNand = nand_q;
      assign outputNor  = nor_q;
      assign outputXnor = xnor_q;
`endif
    end else begin : g_bypass
      assign outputOr  = or_w;
      assign outputAnd = and_w;
      assign outputNot = not_w;
      assign outValid  = inValid;
`ifdef GATES_EXT_EN
      assign outputXor  = xor_w;
      assign outputNand = nand_w;
      assign outputNor  = nor_w;
      assign outputXnor = xnor_w;
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_gates.sv
// +----------------------------------------------------------------------+
// | tb_reg_gates: directed self-checking bench for reg_gates.            |
// | Optional macro: GATES_EXT_EN (extended outputs checked when defined).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_gates;

  logic clk = 1'b0;
  logic rst;
  logic inValid;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;

  logic       or1, and1, not1, v1;
  logic [7:0] or8, and8, not8;
  logic       v8;
  logic [3:0] orb, andb, notb;
  logic       vb;
  logic [3:0] or4, and4, not4;
  logic       v4;
`ifdef GATES_EXT_EN
  logic       x1, na1, no1, xn1;
  logic [7:0] x8, na8, no8, xn8;
  logic [3:0] xb, nab, nob, xnb;
  logic [3:0] x4, na4, no4, xn4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_gates #(.WIDTH(1), .REGISTERED(1'b1)) u1 (
    .clk(clk), .rst(rst), .inA(a1), .inB(b1), .inValid(inValid),
    .outputOr(or1), .outputAnd(and1), .outputNot(not1),
`ifdef GATES_EXT_EN
    .outputXor(x1), .outputNand(na1), .outputNor(no1), .outputXnor(xn1),
`endif
    .outValid(v1));

  reg_gates #(.WIDTH(8), .REGISTERED(1'b1)) u8 (
    .clk(clk), .rst(rst), .inA(a8), .inB(b8), .inValid(inValid),
    .outputOr(or8), .outputAnd(and8), .outputNot(not8),
`ifdef GATES_EXT_EN
    .outputXor(x8), .outputNand(na8), .outputNor(no8), .outputXnor(xn8),
`endif
    .outValid(v8));

  reg_gates #(.WIDTH(4), .REGISTERED(1'b0)) ub (
    .clk(clk), .rst(rst), .inA(a4), .inB(b4), .inValid(inValid),
    .outputOr(orb), .outputAnd(andb), .outputNot(notb),
`ifdef GATES_EXT_EN
    .outputXor(xb), .outputNand(nab), .outputNor(nob), .outputXnor(xnb),
`endif
    .outValid(vb));

  reg_gates #(.WIDTH(4), .REGISTERED(1'b1)) u4 (
    .clk(clk), .rst(rst), .inA(a4), .inB(b4), .inValid(inValid),
    .outputOr(or4), .outputAnd(and4), .outputNot(not4),
`ifdef GATES_EXT_EN
    .outputXor(x4), .outputNand(na4), .outputNor(no4), .outputXnor(xn4),
`endif
    .outValid(v4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vectors (inA,inB) = 00,10,01,11 with hand-computed results.
  logic [3:0] va    = 4'b1010;  // index 0..3 -> bit 0..3
  logic [3:0] vb_in = 4'b1100;
  logic [3:0] e_or  = 4'b1110;
  logic [3:0] e_and = 4'b1000;
  logic [3:0] e_not = 4'b0101;

  initial begin
    rst = 1'b1; inValid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_or1",  {63'd0, or1},  64'd0);
    check("rst_and1", {63'd0, and1}, 64'd0);
    check("rst_not1", {63'd0, not1}, 64'd0);
    check("rst_v1",   {63'd0, v1},   64'd0);
    check("rst_not8", {56'd0, not8}, 64'd0);
    check("rst_not4", {60'd0, not4}, 64'd0);
    check("byp_rst_not", {60'd0, notb}, 64'hF);
`ifdef GATES_EXT_EN
    check("rst_nand4", {60'd0, na4}, 64'd0);
    check("rst_xnor4", {60'd0, xn4}, 64'd0);
`endif

    @(negedge clk);
    rst = 1'b0; inValid = 1'b1;
    a1 = va[0]; b1 = vb_in[0];
    a8 = 8'hF0; b8 = 8'h3C; a4 = 4'hA; b4 = 4'h6;
    #1;
    check("byp_or",  {60'd0, orb},  64'hE);
    check("byp_and", {60'd0, andb}, 64'h2);
    check("byp_not", {60'd0, notb}, 64'h5);
    check("byp_v",   {63'd0, vb},   64'd1);

    @(posedge clk); #1;
    check("vec0_or",  {63'd0, or1},  {63'd0, e_or[0]});
    check("vec0_and", {63'd0, and1}, {63'd0, e_and[0]});
    check("vec0_not", {63'd0, not1}, {63'd0, e_not[0]});
    check("vec0_v",   {63'd0, v1},   64'd1);
    check("w8_or",  {56'd0, or8},  64'hFC);
    check("w8_and", {56'd0, and8}, 64'h30);
    check("w8_not", {56'd0, not8}, 64'h0F);
    check("w8_v",   {63'd0, v8},   64'd1);
    check("w4_or",  {60'd0, or4},  64'hE);
`ifdef GATES_EXT_EN
    check("ext_xor",  {60'd0, x4},  64'hC);
    check("ext_nand", {60'd0, na4}, 64'hD);
    check("ext_nor",  {60'd0, no4}, 64'h1);
    check("ext_xnor", {60'd0, xn4}, 64'h3);
`endif

    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      a1 = va[i]; b1 = vb_in[i];
      if (i == 1) begin a8 = 8'h55; b8 = 8'hFF; end
      @(posedge clk); #1;
      check($sformatf("vec%0d_or", i),  {63'd0, or1},  {63'd0, e_or[i]});
      check($sformatf("vec%0d_and", i), {63'd0, and1}, {63'd0, e_and[i]});
      check($sformatf("vec%0d_not", i), {63'd0, not1}, {63'd0, e_not[i]});
      check($sformatf("vec%0d_v", i),   {63'd0, v1},   64'd1);
    end
    check("w8b_or",  {56'd0, or8},  64'hFF);
    check("w8b_and", {56'd0, and8}, 64'h55);
    check("w8b_not", {56'd0, not8}, 64'hAA);

    // Asynchronous reset mid-stream, between clock edges, inValid still 1.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_or1",  {63'd0, or1},  64'd0);
    check("arst_and1", {63'd0, and1}, 64'd0);
    check("arst_not1", {63'd0, not1}, 64'd0);
    check("arst_v1",   {63'd0, v1},   64'd0);
    check("arst_or8",  {56'd0, or8},  64'd0);
    check("arst_byp_or", {60'd0, orb}, 64'hE);
    check("arst_byp_v",  {63'd0, vb},  64'd1);
`ifdef GATES_EXT_EN
    check("arst_xor4", {60'd0, x4},  64'd0);
    check("arst_nor4", {60'd0, no4}, 64'd0);
`endif
    @(posedge clk); #1;
    check("rsthold_or1", {63'd0, or1}, 64'd0);
    check("rsthold_v1",  {63'd0, v1},  64'd0);

    @(negedge clk);
    rst = 1'b0; inValid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_v1",  {63'd0, v1},  64'd0);
    check("post_rst_or1", {63'd0, or1}, 64'd0);

    // Hold: load (1,0), then drop inValid and change the operands.
    @(negedge clk);
    inValid = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check("load_or",  {63'd0, or1},  64'd1);
    check("load_and", {63'd0, and1}, 64'd0);
    check("load_not", {63'd0, not1}, 64'd0);
    check("load_v",   {63'd0, v1},   64'd1);
    @(negedge clk);
    inValid = 1'b0; a1 = 1'b0; b1 = 1'b1;
    a4 = 4'h3; b4 = 4'h5;
    #1;
    check("byp_v0",  {63'd0, vb},  64'd0);
    check("byp_or2", {60'd0, orb}, 64'h7);
    @(posedge clk); #1;
    check("hold_or",  {63'd0, or1},  64'd1);
    check("hold_and", {63'd0, and1}, 64'd0);
    check("hold_not", {63'd0, not1}, 64'd0);
    check("hold_v",   {63'd0, v1},   64'd0);
    check("hold_or4", {60'd0, or4},  64'hE);
`ifdef GATES_EXT_EN
    check("hold_xor4", {60'd0, x4}, 64'hC);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
